// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman sorter sequencer and the code-length controller.
package huff_pkg;

    localparam int NSYM = 20;
    localparam int W    = 8;
    localparam int AW   = 5;

    // Also used by the code-length controller for debug muxing.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SORT,
        S_DRAIN,
        S_DONE
    } huff_state_t;

    function automatic logic [AW-1:0] clamp_n(input logic [AW-1:0] n);
        return (n > AW'(NSYM)) ? AW'(NSYM) : n;
    endfunction

endpackage

// File: rtl/sort_seq_ctrl.sv
// Sequencer that loads the symbol sorter from the frequency table, waits out the sort,
// captures the sorted stream and flags count/order errors for the canonical-code stage.
module sort_seq_ctrl
    import huff_pkg::*;
#(
    parameter int SORT_CYC  = 64,
    parameter int DRAIN_CYC = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] n_syms,
    output logic          busy,
    output logic          done,
    output logic          err_count,
    output logic          err_order,
    output logic          tbl_rd,
    output logic [AW-1:0] tbl_addr,
    input  logic [W-1:0]  tbl_syml,
    input  logic [W-1:0]  tbl_freq,
    output logic          sort_rst_n,
    output logic          syml_pulse,
    output logic [W-1:0]  syml,
    output logic [W-1:0]  freq,
    output logic          fdone,
    input  logic          sort_enb,
    input  logic [W-1:0]  sort_freq,
    input  logic [W-1:0]  sort_syml,
    output logic          out_valid,
    output logic [W-1:0]  out_syml,
    output logic [W-1:0]  out_freq,
    output logic [AW-1:0] out_idx
);

    localparam int PH_MAX = (SORT_CYC > DRAIN_CYC) ? SORT_CYC : DRAIN_CYC;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam logic [PW-1:0] SORT_LAST  = PW'(SORT_CYC - 1);
    localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYC - 1);
    localparam logic [PW-1:0] CLEAR_LAST = PW'(1);

    huff_state_t   state;
    logic [AW-1:0] n_lat;
    logic [AW-1:0] ld_cnt;
    logic [AW-1:0] nz_cnt;
    logic [AW-1:0] rx_cnt;
    logic [PW-1:0] ph_cnt;
    logic          rd_d1;
    logic [W-1:0]  prev_freq;

    logic          accept;
    logic [AW-1:0] rx_next;

    // rx_next folds in an entry accepted on the final drain cycle so the count check sees it.
    always_comb begin
        accept  = (state == S_DRAIN) && sort_enb;
        rx_next = rx_cnt;
        if (accept && (rx_cnt != AW'(NSYM)))
            rx_next = rx_cnt + AW'(1);
    end

    // NOTE: every register here is updated with <= so all state advances from the same
    // pre-edge values; blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            n_lat      <= '0;
            ld_cnt     <= '0;
            nz_cnt     <= '0;
            rx_cnt     <= '0;
            ph_cnt     <= '0;
            rd_d1      <= 1'b0;
            prev_freq  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= 1'b0;
            err_order  <= 1'b0;
            tbl_rd     <= 1'b0;
            tbl_addr   <= '0;
            sort_rst_n <= 1'b0;
            syml_pulse <= 1'b0;
            syml       <= '0;
            freq       <= '0;
            fdone      <= 1'b0;
            out_valid  <= 1'b0;
            out_syml   <= '0;
            out_freq   <= '0;
            out_idx    <= '0;
        end else begin
            done       <= 1'b0;
            syml_pulse <= 1'b0;
            out_valid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    sort_rst_n <= 1'b1;
                    if (start) begin
                        n_lat      <= clamp_n(n_syms);
                        ld_cnt     <= '0;
                        nz_cnt     <= '0;
                        rx_cnt     <= '0;
                        ph_cnt     <= '0;
                        err_count  <= 1'b0;
                        err_order  <= 1'b0;
                        busy       <= 1'b1;
                        sort_rst_n <= 1'b0;
                        state      <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    ph_cnt <= ph_cnt + PW'(1);
                    if (ph_cnt == CLEAR_LAST) begin
                        ph_cnt     <= '0;
                        sort_rst_n <= 1'b1;
                        if (n_lat == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            tbl_rd   <= 1'b1;
                            tbl_addr <= '0;
                            state    <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    rd_d1 <= tbl_rd;
                    if (tbl_rd) begin
                        if (tbl_addr == n_lat - AW'(1)) begin
                            tbl_rd   <= 1'b0;
                            tbl_addr <= '0;
                        end else begin
                            tbl_addr <= tbl_addr + AW'(1);
                        end
                    end
                    // Table data is valid the cycle after its read strobe.
                    if (rd_d1) begin
                        syml_pulse <= 1'b1;
                        syml       <= tbl_syml;
                        freq       <= tbl_freq;
                        ld_cnt     <= ld_cnt + AW'(1);
                        if ((tbl_freq != '0) && (nz_cnt != AW'(NSYM)))
                            nz_cnt <= nz_cnt + AW'(1);
                    end
                    if (syml_pulse && (ld_cnt == n_lat)) begin
                        fdone  <= 1'b1;
                        ph_cnt <= '0;
                        state  <= S_SORT;
                    end
                end

                S_SORT: begin
                    ph_cnt <= ph_cnt + PW'(1);
                    if (ph_cnt == SORT_LAST) begin
                        ph_cnt <= '0;
                        state  <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    ph_cnt <= ph_cnt + PW'(1);
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_syml  <= sort_syml;
                        out_freq  <= sort_freq;
                        out_idx   <= rx_cnt;
                        rx_cnt    <= rx_next;
                        prev_freq <= sort_freq;
                        if ((rx_cnt != '0) && (sort_freq < prev_freq))
                            err_order <= 1'b1;
                    end
                    if (ph_cnt == DRAIN_LAST) begin
                        ph_cnt    <= '0;
                        fdone     <= 1'b0;
                        done      <= 1'b1;
                        err_count <= err_count | (rx_next != nz_cnt);
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench: table and sorter responders plus a reference model of each run.
module tb_sort_seq_ctrl;
    import huff_pkg::*;

    localparam int SORT_CYC  = 64;
    localparam int DRAIN_CYC = 24;
    localparam int EMIT_AT   = SORT_CYC + 1;

    typedef struct {
        logic [7:0] s;
        logic [7:0] f;
    } ent_t;

    typedef struct {
        logic [4:0] idx;
        logic [7:0] s;
        logic [7:0] f;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] n_syms;
    logic       busy, done, err_count, err_order;
    logic       tbl_rd;
    logic [4:0] tbl_addr;
    logic [7:0] tbl_syml, tbl_freq;
    logic       sort_rst_n, syml_pulse;
    logic [7:0] syml, freq;
    logic       fdone;
    logic       sort_enb;
    logic [7:0] sort_freq, sort_syml;
    logic       out_valid;
    logic [7:0] out_syml, out_freq;
    logic [4:0] out_idx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_s [32];
    logic [7:0] mem_f [32];
    ent_t       emit_q[$];

    int   cyc = 0;
    int   rd_q[$];
    ent_t pl_q[$];
    out_t out_q[$];
    int   first_pl, last_pl, first_fd, fd_cycles, done_cnt;
    int   fd_cnt = 0;

    sort_seq_ctrl #(.SORT_CYC(SORT_CYC), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .n_syms(n_syms),
        .busy(busy), .done(done), .err_count(err_count), .err_order(err_order),
        .tbl_rd(tbl_rd), .tbl_addr(tbl_addr), .tbl_syml(tbl_syml), .tbl_freq(tbl_freq),
        .sort_rst_n(sort_rst_n), .syml_pulse(syml_pulse), .syml(syml), .freq(freq),
        .fdone(fdone), .sort_enb(sort_enb), .sort_freq(sort_freq), .sort_syml(sort_syml),
        .out_valid(out_valid), .out_syml(out_syml), .out_freq(out_freq), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // Frequency table: registered read, data valid the cycle after tbl_rd.
    always @(posedge clk) begin
        if (tbl_rd) begin
            tbl_syml <= mem_s[tbl_addr];
            tbl_freq <= mem_f[tbl_addr];
        end
    end

    // Sorter stand-in: a stray strobe during SORT, then plays emit_q inside the drain window.
    always @(posedge clk) begin
        if (!fdone) begin
            fd_cnt   <= 0;
            sort_enb <= 1'b0;
        end else begin
            fd_cnt <= fd_cnt + 1;
            if (fd_cnt == 10) begin
                sort_enb  <= 1'b1;
                sort_freq <= 8'hAA;
                sort_syml <= 8'h55;
            end else if (fd_cnt >= EMIT_AT && (fd_cnt - EMIT_AT) < emit_q.size()) begin
                sort_enb  <= 1'b1;
                sort_freq <= emit_q[fd_cnt - EMIT_AT].f;
                sort_syml <= emit_q[fd_cnt - EMIT_AT].s;
            end else begin
                sort_enb <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        out_t o;
        ent_t e;
        cyc++;
        if (tbl_rd) rd_q.push_back(int'(tbl_addr));
        if (syml_pulse) begin
            e.s = syml;
            e.f = freq;
            pl_q.push_back(e);
            if (first_pl < 0) first_pl = cyc;
            last_pl = cyc;
        end
        if (fdone) begin
            fd_cycles++;
            if (first_fd < 0) first_fd = cyc;
        end
        if (out_valid) begin
            o.idx = out_idx;
            o.s   = out_syml;
            o.f   = out_freq;
            out_q.push_back(o);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q      = {};
        pl_q      = {};
        out_q     = {};
        first_pl  = -1;
        last_pl   = -1;
        first_fd  = -1;
        fd_cycles = 0;
        done_cnt  = 0;
    endtask

    task automatic fill_table(input int n, input int zero_pct);
        for (int i = 0; i < 32; i++) begin
            mem_s[i] = 8'($urandom_range(0, 255));
            mem_f[i] = ($urandom_range(0, 99) < zero_pct) ? 8'd0 : 8'($urandom_range(1, 255));
        end
    endtask

    // One complete run checked against a model built from the table contents.
    task automatic run_case(input string name, input int n_req, input bit drop,
                            input bit bad, input bit poke);
        ent_t srt[$];
        ent_t e, tmp;
        int   n, pos, lat, exp_lat, nz;
        bit   got_done, exp_ecnt, exp_eord;
        logic ecnt, eord;

        n   = (n_req > NSYM) ? NSYM : n_req;
        srt = {};
        for (int i = 0; i < n; i++) begin
            if (mem_f[i] != 8'd0) begin
                e.s = mem_s[i];
                e.f = mem_f[i];
                pos = srt.size();
                for (int j = 0; j < srt.size(); j++) begin
                    if (srt[j].f > e.f) begin
                        pos = j;
                        break;
                    end
                end
                srt.insert(pos, e);
            end
        end
        nz     = srt.size();
        emit_q = srt;
        if (drop && emit_q.size() > 0) emit_q.delete($urandom_range(0, emit_q.size() - 1));
        if (bad && emit_q.size() >= 2) begin
            tmp       = emit_q[0];
            emit_q[0] = emit_q[1];
            emit_q[1] = tmp;
        end
        exp_ecnt = (emit_q.size() != nz);
        exp_eord = 1'b0;
        for (int i = 1; i < emit_q.size(); i++)
            if (emit_q[i].f < emit_q[i-1].f) exp_eord = 1'b1;
        exp_lat = (n == 0) ? 3 : n + 5 + SORT_CYC + DRAIN_CYC;

        @(negedge clk);
        clear_mon();
        start    = 1'b1;
        n_syms   = 5'(n_req);
        lat      = 0;
        got_done = 1'b0;
        ecnt     = 1'b0;
        eord     = 1'b0;
        while (lat < 400 && !got_done) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                check({name, " busy_after_start"}, 64'(busy), 64'd1);
            end
            if (lat <= 2) check({name, " sort_rst_n_clear"}, 64'(sort_rst_n), 64'd0);
            if (lat == 3) check({name, " sort_rst_n_release"}, 64'(sort_rst_n), 64'd1);
            if (poke && lat == n + 20) begin
                start  = 1'b1;
                n_syms = 5'd3;
            end
            if (poke && lat == n + 21) begin
                start = 1'b0;
                check({name, " busy_ignores_start"}, 64'(busy), 64'd1);
            end
            if (done) begin
                got_done = 1'b1;
                ecnt     = err_count;
                eord     = err_order;
            end
        end
        check({name, " done_seen"}, 64'(got_done), 64'd1);
        check({name, " done_latency"}, 64'(lat), 64'(exp_lat));
        check({name, " err_count"}, 64'(ecnt), 64'(exp_ecnt));
        check({name, " err_order"}, 64'(eord), 64'(exp_eord));
        @(negedge clk);
        @(negedge clk);
        check({name, " busy_after_done"}, 64'(busy), 64'd0);
        check({name, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, " read_count"}, 64'(rd_q.size()), 64'(n));
        for (int i = 0; i < rd_q.size() && i < n; i++)
            check($sformatf("%s tbl_addr[%0d]", name, i), 64'(rd_q[i]), 64'(i));
        check({name, " pulse_count"}, 64'(pl_q.size()), 64'(n));
        for (int i = 0; i < pl_q.size() && i < n; i++) begin
            check($sformatf("%s load[%0d]", name, i), {48'd0, pl_q[i].s, pl_q[i].f},
                  {48'd0, mem_s[i], mem_f[i]});
        end
        if (n > 0) begin
            check({name, " pulses_back_to_back"}, 64'(last_pl - first_pl + 1), 64'(n));
            check({name, " sort_after_last_pulse"}, 64'(first_fd), 64'(last_pl + 1));
        end
        check({name, " fdone_cycles"}, 64'(fd_cycles),
              64'((n == 0) ? 0 : SORT_CYC + DRAIN_CYC));
        check({name, " out_count"}, 64'(out_q.size()), 64'(emit_q.size()));
        for (int i = 0; i < out_q.size() && i < emit_q.size(); i++) begin
            check($sformatf("%s out[%0d]", name, i), {40'd0, out_q[i].idx, out_q[i].s, out_q[i].f},
                  {40'd0, 5'(i), emit_q[i].s, emit_q[i].f});
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, err_count, err_order, tbl_rd, tbl_addr, sort_rst_n, syml_pulse,
                    syml, freq, fdone, out_valid, out_syml, out_freq, out_idx});
    endfunction

    initial begin
        int k;
        bit hit;
        reset  = 1'b0;
        start  = 1'b0;
        n_syms = 5'd0;
        tbl_syml = 8'd0;
        tbl_freq = 8'd0;
        clear_mon();
        for (int i = 0; i < 32; i++) begin
            mem_s[i] = 8'd0;
            mem_f[i] = 8'd0;
        end

        // Reset state and sorter release.
        #1;
        check("reset_all_outputs_zero", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("sort_rst_n_after_reset", 64'(sort_rst_n), 64'd1);
        check("idle_not_busy", 64'(busy), 64'd0);

        // 1: basic sort of four entries.
        mem_s[0] = 8'h10; mem_f[0] = 8'd5;
        mem_s[1] = 8'h11; mem_f[1] = 8'd2;
        mem_s[2] = 8'h12; mem_f[2] = 8'd9;
        mem_s[3] = 8'h13; mem_f[3] = 8'd1;
        run_case("t1", 4, 1'b0, 1'b0, 1'b0);

        // 2: zero frequencies are not expected back from the sorter.
        mem_s[0] = 8'h20; mem_f[0] = 8'd3;
        mem_s[1] = 8'h21; mem_f[1] = 8'd0;
        mem_s[2] = 8'h22; mem_f[2] = 8'd7;
        mem_s[3] = 8'h23; mem_f[3] = 8'd0;
        run_case("t2", 4, 1'b0, 1'b0, 1'b0);

        // 3: empty run.
        run_case("t3", 0, 1'b0, 1'b0, 1'b0);

        // 4: request above capacity is clamped; one sorted entry goes missing.
        fill_table(32, 0);
        run_case("t4", 25, 1'b1, 1'b0, 1'b0);

        // 5: out-of-order pair 8 then 6, plus a start pulse while sorting.
        mem_s[0] = 8'h41; mem_f[0] = 8'd6;
        mem_s[1] = 8'h42; mem_f[1] = 8'd8;
        run_case("t5", 2, 1'b0, 1'b1, 1'b1);

        // Randomised runs including zero frequencies.
        for (int r = 0; r < 3; r++) begin
            fill_table(32, 25);
            run_case($sformatf("rand%0d", r), $urandom_range(1, NSYM), 1'b0, 1'b0, 1'b0);
        end

        // 6: reset while loading at address 2, then a clean rerun.
        fill_table(32, 0);
        @(negedge clk);
        clear_mon();
        start  = 1'b1;
        n_syms = 5'd6;
        k      = 0;
        hit    = 1'b0;
        while (k < 30 && !hit) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (tbl_rd && tbl_addr == 5'd2) hit = 1'b1;
        end
        check("t6 reached_addr2", 64'(hit), 64'd1);
        reset = 1'b0;
        #1;
        check("t6 outputs_cleared", all_outs(), 64'd0);
        repeat (4) @(negedge clk);
        check("t6 sorter_held", 64'(sort_rst_n), 64'd0);
        check("t6 no_done", 64'(done_cnt), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("t6 idle_after_abort", 64'(busy), 64'd0);
        fill_table(32, 20);
        run_case("t6_rerun", 7, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
